// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine
// HD44780-style character LCD transfer engine. Accepts one command per
// valid/ready handshake and sequences LCD_E, LCD_RS, LCD_RW and the data
// bus with programmable setup / enable / hold / gap timing, in 4-bit
// (two nibbles, high first) or 8-bit (single transfer) bus mode. Reads
// capture SF_DIN into rd_data. After the transfer the engine waits
// T_CMD cycles, or T_CLEAR cycles for clear display / return home.
//
// Optional build macro: LCD_BUSY_POLL_EN
//   When defined, the fixed post-command wait is replaced by busy-flag
//   polling: internal reads (RS=0, RW=1) repeat until the captured bit 7
//   is 0 or T_CLEAR wait cycles have elapsed. Poll reads never pulse
//   rd_valid.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   in_valid  command present
//   in_ready  engine idle, a command is accepted when in_valid is also high
//   in_rs     register select for the command
//   in_rw     1 = read, 0 = write
//   in_data   byte to write
//   SF_D      data bus drive value
//   SF_OE     bus output enable, high only during write transfers
//   SF_DIN    data bus value returned by the LCD
//   LCD_E     enable strobe
//   LCD_RS    register select
//   LCD_RW    read/write
//   rd_data   captured read byte
//   rd_valid  one-cycle pulse when rd_data is updated
module lcd_cmd_engine #(
  parameter int BUS_W   = 4,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000,
  parameter int CNT_W   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rs,
  input  logic             in_rw,
  input  logic [7:0]       in_data,
  output logic [BUS_W-1:0] SF_D,
  output logic             SF_OE,
  input  logic [BUS_W-1:0] SF_DIN,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic [7:0]       rd_data,
  output logic             rd_valid
);

  // A zero timing parameter still gives its state one cycle.
  localparam int N_SETUP = (T_SETUP < 1) ? 1 : T_SETUP;
  localparam int N_EN    = (T_EN    < 1) ? 1 : T_EN;
  localparam int N_HOLD  = (T_HOLD  < 1) ? 1 : T_HOLD;
  localparam int N_GAP   = (T_GAP   < 1) ? 1 : T_GAP;
  localparam int N_CMD   = (T_CMD   < 1) ? 1 : T_CMD;
  localparam int N_CLEAR = (T_CLEAR < 1) ? 1 : T_CLEAR;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(N_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(N_EN - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(N_HOLD - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(N_GAP - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(N_CMD - 1);
  localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(N_CLEAR - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_GAP, S_WAIT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rs_q, rs_n, rw_q, rw_n;
  logic [7:0]       data_q, data_n;
  logic             second_q, second_n;
  logic             clear_q, clear_n;
  logic [7:0]       rd_shift, shift_n;
  logic [7:0]       rd_data_n;
  logic             rd_valid_n;
  logic             active_n;
  logic [BUS_W-1:0] bus_n;
`ifdef LCD_BUSY_POLL_EN
  logic             poll_q, poll_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
`endif

  // Next-state logic; every output is registered from the next state so
  // the pins change cleanly on the clock edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    rs_n       = rs_q;
    rw_n       = rw_q;
    data_n     = data_q;
    second_n   = second_q;
    clear_n    = clear_q;
    shift_n    = rd_shift;
    rd_data_n  = rd_data;
    rd_valid_n = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_n     = poll_q;
    wait_cnt_n = poll_q ? (&wait_cnt ? wait_cnt : wait_cnt + 1'b1) : '0;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (in_valid) begin
          state_n  = S_SETUP;
          rs_n     = in_rs;
          rw_n     = in_rw;
          data_n   = in_data;
          second_n = 1'b0;
          // Clear display (0x01) and return home (0x02/0x03) need the long wait.
          clear_n  = ~in_rs & ~in_rw & (in_data[7:2] == 6'd0) & (in_data[1:0] != 2'd0);
        end
      end
      S_SETUP: if (cnt == L_SETUP) begin
        state_n = S_EN_HI;
        cnt_n   = '0;
      end
      S_EN_HI: if (cnt == L_EN) begin
        state_n = S_HOLD;
        cnt_n   = '0;
        if (rw_q) begin
          if (BUS_W == 4) begin
            if (!second_q) shift_n[7:4] = SF_DIN[3:0];
            else           shift_n[3:0] = SF_DIN[3:0];
          end else begin
            shift_n = 8'(SF_DIN);
          end
        end
      end
      S_HOLD: if (cnt == L_HOLD) begin
        cnt_n = '0;
        if ((BUS_W == 4) && !second_q) begin
          state_n  = S_GAP;
          second_n = 1'b1;
        end
`ifdef LCD_BUSY_POLL_EN
        else if (!poll_q) begin
          // User transfer done: report a user read, then start polling.
          rd_valid_n = rw_q;
          if (rw_q) rd_data_n = rd_shift;
          poll_n   = 1'b1;
          rs_n     = 1'b0;
          rw_n     = 1'b1;
          data_n   = '0;
          second_n = 1'b0;
          state_n  = S_SETUP;
        end else if (!rd_shift[7] || (wait_cnt >= L_CLEAR)) begin
          poll_n   = 1'b0;
          rw_n     = 1'b0;
          second_n = 1'b0;
          state_n  = S_IDLE;
        end else begin
          second_n = 1'b0;
          state_n  = S_SETUP;
        end
`else
        else begin
          state_n    = S_WAIT;
          rd_valid_n = rw_q;
          if (rw_q) rd_data_n = rd_shift;
        end
`endif
      end
      S_GAP: if (cnt == L_GAP) begin
        state_n = S_SETUP;
        cnt_n   = '0;
      end
      S_WAIT: if (cnt == (clear_q ? L_CLEAR : L_CMD)) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Bus is driven only while a transfer is in SETUP/EN_HI/HOLD.
    active_n = (state_n == S_SETUP) || (state_n == S_EN_HI) || (state_n == S_HOLD);
    bus_n    = '0;
    if (active_n) begin
      if (BUS_W == 4) bus_n = BUS_W'(second_n ? data_n[3:0] : data_n[7:4]);
      else            bus_n = BUS_W'(data_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      second_q <= 1'b0;
      clear_q  <= 1'b0;
      rd_shift <= '0;
      in_ready <= 1'b1;
      SF_D     <= '0;
      SF_OE    <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q   <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rs_q     <= rs_n;
      rw_q     <= rw_n;
      data_q   <= data_n;
      second_q <= second_n;
      clear_q  <= clear_n;
      rd_shift <= shift_n;
      in_ready <= (state_n == S_IDLE);
      SF_D     <= bus_n;
      SF_OE    <= active_n & ~rw_n;
      LCD_E    <= (state_n == S_EN_HI);
      LCD_RS   <= active_n & rs_n;
      LCD_RW   <= active_n & rw_n;
      rd_data  <= rd_data_n;
      rd_valid <= rd_valid_n;
`ifdef LCD_BUSY_POLL_EN
      poll_q   <= poll_n;
      wait_cnt <= wait_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// tb_lcd_cmd_engine
// Self-checking bench for lcd_cmd_engine. Three instances share clock,
// reset and command fields: dut4 (4-bit, default timing), dut8 (8-bit,
// T_CMD=200, T_CLEAR=500) and dut_l (4-bit, default timing) which runs the
// 82000-cycle clear wait alongside the other tests.
module tb_lcd_cmd_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_rs = 1'b0, in_rw = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [3:0] din4 = 4'h0;
  logic [7:0] din8 = 8'h00;

  logic v4 = 1'b0, rdy4, oe4, e4, rs4, rw4, rdv4;
  logic [3:0] d4;
  logic [7:0] rdd4;
  logic v8 = 1'b0, rdy8, oe8, e8, rs8, rw8, rdv8;
  logic [7:0] d8, rdd8;
  logic vl = 1'b0, rdyl, oel, el, rsl, rwl, rdvl;
  logic [3:0] dl;
  logic [7:0] rddl;

  always #5 clk = ~clk;

  lcd_cmd_engine dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_rs(in_rs),
    .in_rw(in_rw), .in_data(in_data), .SF_D(d4), .SF_OE(oe4), .SF_DIN(din4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .rd_data(rdd4), .rd_valid(rdv4));

  lcd_cmd_engine #(.BUS_W(8), .T_CMD(200), .T_CLEAR(500)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_rs(in_rs),
    .in_rw(in_rw), .in_data(in_data), .SF_D(d8), .SF_OE(oe8), .SF_DIN(din8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .rd_data(rdd8), .rd_valid(rdv8));

  lcd_cmd_engine dut_l (
    .clk(clk), .reset(reset), .in_valid(vl), .in_ready(rdyl), .in_rs(in_rs),
    .in_rw(in_rw), .in_data(in_data), .SF_D(dl), .SF_OE(oel), .SF_DIN(din4),
    .LCD_E(el), .LCD_RS(rsl), .LCD_RW(rwl), .rd_data(rddl), .rd_valid(rdvl));

  // Monitor mux: 0 = dut4, 1 = dut8, other = dut_l
  int sel = 0;
  logic mon_ready, mon_e, mon_oe, mon_rs, mon_rw, mon_rdv;
  logic [7:0] mon_d, mon_rdd;
  always_comb begin
    case (sel)
      0: begin
        mon_ready = rdy4; mon_e = e4; mon_oe = oe4; mon_rs = rs4; mon_rw = rw4;
        mon_d = {4'h0, d4}; mon_rdv = rdv4; mon_rdd = rdd4;
      end
      1: begin
        mon_ready = rdy8; mon_e = e8; mon_oe = oe8; mon_rs = rs8; mon_rw = rw8;
        mon_d = d8; mon_rdv = rdv8; mon_rdd = rdd8;
      end
      default: begin
        mon_ready = rdyl; mon_e = el; mon_oe = oel; mon_rs = rsl; mon_rw = rwl;
        mon_d = {4'h0, dl}; mon_rdv = rdvl; mon_rdd = rddl;
      end
    endcase
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Per-strobe SF_DIN values and results of the last watch() call
  logic [7:0] din_tab [10];
  int m_cycles, m_strobes, m_emin, m_emax, m_low, m_lowoe, m_oe_e;
  int m_rdv, m_rwstrobes, m_timeout;
  logic [7:0] m_d0, m_d1, m_rd;
  logic m_rs, m_rw;

  // Drive a command at a negedge; it is accepted on the following posedge.
  task automatic applyStimulus(input int s, input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    in_rs = rs; in_rw = rw; in_data = d;
    if (s == 0) v4 = 1'b1; else if (s == 1) v8 = 1'b1; else vl = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0; v8 = 1'b0; vl = 1'b0;
  endtask

  // Sample the selected instance each negedge until in_ready returns.
  task automatic watch(input int limit);
    logic prev_e = 1'b0;
    int run = 0;
    bit done = 1'b0;
    m_cycles = 0; m_strobes = 0; m_emin = 1000000; m_emax = 0; m_low = 0;
    m_lowoe = 0; m_oe_e = 0; m_rdv = 0; m_rwstrobes = 0; m_timeout = 0;
    m_d0 = 8'h00; m_d1 = 8'h00; m_rd = 8'h00; m_rs = 1'b0; m_rw = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (mon_e && !prev_e) begin
        m_strobes++;
        run = 0;
        if (m_strobes <= 10) begin
          din8 = din_tab[m_strobes-1];
          din4 = din8[3:0];
        end
        if (m_strobes == 1) begin m_d0 = mon_d; m_rs = mon_rs; m_rw = mon_rw; end
        if (m_strobes == 2) m_d1 = mon_d;
        if (mon_rw) m_rwstrobes++;
      end
      if (mon_e) begin
        run++;
        if (mon_oe) m_oe_e++;
      end
      if (!mon_e && prev_e) begin
        if (run < m_emin) m_emin = run;
        if (run > m_emax) m_emax = run;
      end
      if (!mon_e && (m_strobes == 1)) begin
        m_low++;
        if (!mon_oe) m_lowoe++;
      end
      if (mon_rdv) begin m_rdv++; m_rd = mon_rdd; end
      if (mon_ready) begin done = 1'b1; break; end
      m_cycles++;
      prev_e = mon_e;
    end
    if (!done) m_timeout = 1;
  endtask

  typedef struct {
    int         sel;
    logic       rs;
    logic       rw;
    logic [7:0] data;
    logic [7:0] din0;
    logic [7:0] din1;
    int         cyc;
    int         strobes;
    logic [7:0] d0;
    logic [7:0] d1;
    int         rdv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [8];

  task automatic resetChecks();
    checkOutput("rst_ready4", int'(rdy4), 1);
    checkOutput("rst_e4", int'(e4), 0);
    checkOutput("rst_oe4", int'(oe4), 0);
    checkOutput("rst_d4", int'(d4), 0);
    checkOutput("rst_rs4", int'(rs4), 0);
    checkOutput("rst_rw4", int'(rw4), 0);
    checkOutput("rst_rdv4", int'(rdv4), 0);
    checkOutput("rst_rdd4", int'(rdd4), 0);
    checkOutput("rst_ready8", int'(rdy8), 1);
    checkOutput("rst_d8", int'(d8), 0);
  endtask

  // Pull reset low in the middle of EN_HI on dut4.
  task automatic resetAbort();
    bit seen = 1'b0;
    sel = 0;
    applyStimulus(0, 1'b1, 1'b0, 8'h48);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mon_e) begin seen = 1'b1; break; end
    end
    checkOutput("abort_e_seen", int'(seen), 1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_e_now", int'(e4), 0);
    checkOutput("abort_oe_now", int'(oe4), 0);
    checkOutput("abort_ready_now", int'(rdy4), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_ready_after", int'(rdy4), 1);
    checkOutput("abort_e_after", int'(e4), 0);
    checkOutput("abort_d_after", int'(d4), 0);
    checkOutput("abort_rs_after", int'(rs4), 0);
    checkOutput("abort_oe_after", int'(oe4), 0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) din_tab[i] = 8'h00;
    vecs[0] = '{0, 1'b1, 1'b0, 8'h48, 8'h00, 8'h00, 2080, 2, 8'h04, 8'h08, 0, 8'h00};
    vecs[1] = '{0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 2080, 2, 8'h08, 8'h00, 0, 8'h00};
    vecs[2] = '{0, 1'b0, 1'b1, 8'h00, 8'h03, 8'h0C, 2080, 2, 8'h00, 8'h00, 1, 8'h3C};
    vecs[3] = '{1, 1'b1, 1'b1, 8'h00, 8'hA5, 8'h00, 215,  1, 8'h00, 8'h00, 1, 8'hA5};
    vecs[4] = '{1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 515,  1, 8'h02, 8'h00, 0, 8'h00};
    vecs[5] = '{1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 215,  1, 8'h00, 8'h00, 0, 8'h00};
    vecs[6] = '{1, 1'b0, 1'b1, 8'h01, 8'h5A, 8'h00, 215,  1, 8'h00, 8'h00, 1, 8'h5A};
    vecs[7] = '{1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 215,  1, 8'h01, 8'h00, 0, 8'h00};

    repeat (2) @(negedge clk);
    #1;
    resetChecks();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef LCD_BUSY_POLL_EN
    resetAbort();
    // Write, then four polls: busy (bit 3 of upper nibble) for three polls.
    din_tab[2] = 8'h08; din_tab[4] = 8'h08; din_tab[6] = 8'h08;
    sel = 0;
    applyStimulus(0, 1'b1, 1'b0, 8'h48);
    watch(5000);
    checkOutput("poll_timeout", m_timeout, 0);
    checkOutput("poll_strobes", m_strobes, 10);
    checkOutput("poll_reads", m_rwstrobes / 2, 4);
    checkOutput("poll_rdv", m_rdv, 0);
    checkOutput("poll_cycles", m_cycles, 400);
`else
    sel = 2;
    applyStimulus(2, 1'b0, 1'b0, 8'h01);
    fork
      begin
        int lc = 0;
        int ls = 0;
        logic pe = 1'b0;
        bit ld = 1'b0;
        for (int c = 0; c < 90000; c++) begin
          @(negedge clk);
          if (el && !pe) ls++;
          pe = el;
          if (rdyl) begin ld = 1'b1; break; end
          lc++;
        end
        checkOutput("clear_done", int'(ld), 1);
        checkOutput("clear_cycles", lc, 82080);
        checkOutput("clear_strobes", ls, 2);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          sel = vecs[i].sel;
          din_tab[0] = vecs[i].din0;
          din_tab[1] = vecs[i].din1;
          applyStimulus(vecs[i].sel, vecs[i].rs, vecs[i].rw, vecs[i].data);
          watch(3000);
          checkOutput($sformatf("v%0d_timeout", i), m_timeout, 0);
          checkOutput($sformatf("v%0d_cycles", i), m_cycles, vecs[i].cyc);
          checkOutput($sformatf("v%0d_strobes", i), m_strobes, vecs[i].strobes);
          checkOutput($sformatf("v%0d_emin", i), m_emin, 12);
          checkOutput($sformatf("v%0d_emax", i), m_emax, 12);
          checkOutput($sformatf("v%0d_rs", i), int'(m_rs), int'(vecs[i].rs));
          checkOutput($sformatf("v%0d_rw", i), int'(m_rw), int'(vecs[i].rw));
          checkOutput($sformatf("v%0d_oe", i), m_oe_e, vecs[i].rw ? 0 : 12 * vecs[i].strobes);
          checkOutput($sformatf("v%0d_rdv", i), m_rdv, vecs[i].rdv);
          if (vecs[i].rdv != 0)
            checkOutput($sformatf("v%0d_rd", i), int'(m_rd), int'(vecs[i].rd));
          if (!vecs[i].rw)
            checkOutput($sformatf("v%0d_d0", i), int'(m_d0), int'(vecs[i].d0));
          if (vecs[i].strobes == 2) begin
            if (!vecs[i].rw)
              checkOutput($sformatf("v%0d_d1", i), int'(m_d1), int'(vecs[i].d1));
            checkOutput($sformatf("v%0d_low", i), m_low, 53);
            checkOutput($sformatf("v%0d_gap", i), m_lowoe, vecs[i].rw ? 53 : 50);
          end
        end

        // in_valid held high while busy: one transfer with the latched byte,
        // then the second command only after the engine is idle again.
        sel = 1;
        @(negedge clk);
        in_rs = 1'b1; in_rw = 1'b0; in_data = 8'h30; v8 = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h31;
        watch(3000);
        checkOutput("held_timeout1", m_timeout, 0);
        checkOutput("held_cycles1", m_cycles, 215);
        checkOutput("held_strobes1", m_strobes, 1);
        checkOutput("held_d1", int'(m_d0), 8'h30);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        watch(3000);
        checkOutput("held_timeout2", m_timeout, 0);
        checkOutput("held_cycles2", m_cycles, 215);
        checkOutput("held_strobes2", m_strobes, 1);
        checkOutput("held_d2", int'(m_d0), 8'h31);
      end
    join
    resetAbort();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
